chunked_adder: RTL
==================

# chunked_adder

Parametrised multi-cycle ripple adder/subtractor. Operands of WIDTH bits are processed one CHUNK-bit ripple slice per clock, LSB slice first, with the carry held in a register between slices. Trades latency for area against a full-width combinational ripple chain. Serves as the general-purpose arithmetic unit behind the team's start/done-controlled datapaths.

## Interface

- WIDTH, 16, operand and result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits processed per cycle; N = WIDTH/CHUNK slices (N ≥ 1)

- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  reset, asynchronous, active-high
- START  input  1  request; sampled only in IDLE
- SUB  input  1  0 = add, 1 = subtract; sampled with START
- A  input  WIDTH  operand A; sampled with START
- B  input  WIDTH  operand B; sampled with START
- CIN  input  1  carry-in (add) / borrow-in (subtract); sampled with START
- BUSY  output  1  high while a slice computation is in progress
- DONE  output  1  single-cycle pulse; result valid
- SUM  output  WIDTH  result
- COUT  output  1  carry-out of MSB (subtract: 1 = no borrow)
- OVF  output  1  two's-complement signed overflow

## Operation

- States: IDLE, RUN.
- IDLE, START=1: latch A; latch B_eff = SUB ? ~B : B; carry register = SUB ? ~CIN : CIN; slice index = 0; go to RUN.
- Add computes A + B + CIN; subtract computes A − B − CIN (as A + ~B + ~CIN).
- RUN, each edge: slice k = index; {c, s} = A[k] + B_eff[k] + carry, all CHUNK bits wide; s written to internal work register slice k; carry ← c; index increments.
- After slice N−1: SUM ← work register (with final slice), COUT ← final carry, OVF ← carry into MSB XOR carry out of MSB; DONE=1 for one cycle; return to IDLE.
- SUM/COUT/OVF change only on the DONE-update edge; they hold the previous result during RUN and until the next completion.
- START while in RUN ignored (no queueing); A/B/SUB/CIN changes during RUN have no effect.
- START high in the DONE cycle is accepted (state is IDLE), giving back-to-back operations.
- N=1 (CHUNK=WIDTH): one RUN cycle, behaves as a registered full-width adder.
- Slice index counter sized ceil(log2(N)) bits, minimum 1; wraps only via return to IDLE.

## Timing

- Reset (async assert, any time): state IDLE, index 0, carry 0, work register 0; BUSY=0, DONE=0, SUM=0, COUT=0, OVF=0. Reset mid-RUN aborts: no DONE, outputs return to 0.
- START sampled high at edge of cycle 0: BUSY=1 in cycles 1..N; DONE=1 and BUSY=0 in cycle N+1; new SUM/COUT/OVF visible from cycle N+1.
- Latency START→DONE = N+1 cycles; throughput one operation per N+1 cycles with back-to-back START.
- BUSY and DONE never both high.
- Outputs registered; no combinational path from inputs to outputs.

## Test plan

- Reset: assert RST mid-cycle without clock → BUSY, DONE, SUM, COUT, OVF all 0 immediately; hold RST, pulse START → nothing happens.
- Add, WIDTH=16/CHUNK=4: A=0x1234, B=0x4321, CIN=0, SUB=0 → BUSY cycles 1–4, DONE cycle 5, SUM=0x5555, COUT=0, OVF=0.
- Full carry ripple: A=0xFFFF, B=0x0001, CIN=0 → SUM=0x0000, COUT=1, OVF=0; then A=0x7FFF, B=0x0001 → SUM=0x8000, COUT=0, OVF=1.
- Subtract: SUB=1, A=0x0005, B=0x0007, CIN=0 → SUM=0xFFFE, COUT=0, OVF=0; SUB=1, A=0x8000, B=0x0001, CIN=0 → SUM=0x7FFF, COUT=1, OVF=1.
- Handshake: START re-asserted in cycles 2–3 with different operands → ignored, first result unchanged; START in DONE cycle with A=0x0001, B=0x0002 → second DONE 5 cycles later, SUM=0x0003.
- Abort and parameters: RST pulse in cycle 2 of RUN → no DONE, outputs 0, next START completes normally; repeat add vectors with CHUNK=16 (DONE cycle 2) and CHUNK=1 (DONE cycle 17), identical results.

Source files
------------

// File: rtl/chunked_adder.sv
// Multi-cycle ripple adder/subtractor: one CHUNK-bit slice per clock, LSB slice first,
// carry held in a register between slices. Result registers update only on the DONE edge.
module chunked_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             SUB,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT,
   output logic             OVF
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   logic [0:0]       state_q;
   logic [IW-1:0]    idx_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q, b_q, work_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q, done_q;

   int unsigned      base;
   logic [CHUNK-1:0] a_sl, b_sl, s_sl;
   logic             c_sl, ovf_sl;
   logic [WIDTH-1:0] work_d;

   always_comb begin
      base = 32'(idx_q) * CHUNK;
      a_sl = a_q[base +: CHUNK];
      b_sl = b_q[base +: CHUNK];
      {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
      // Carry into the slice MSB recovered from its sum bit; only used on the last slice.
      ovf_sl = c_sl ^ a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ s_sl[CHUNK-1];
      work_d = work_q;
      work_d[base +: CHUNK] = s_sl;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (START) begin
                  a_q     <= A;
                  b_q     <= SUB ? ~B : B;
                  carry_q <= SUB ? ~CIN : CIN;
                  idx_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               work_q  <= work_d;
               carry_q <= c_sl;
               idx_q   <= idx_q + 1'b1;
               if (idx_q == LAST) begin
                  sum_q   <= work_d;
                  cout_q  <= c_sl;
                  ovf_q   <= ovf_sl;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign BUSY = (state_q == RUN);
   assign DONE = done_q;
   assign SUM  = sum_q;
   assign COUT = cout_q;
   assign OVF  = ovf_q;

endmodule
